// File: rtl/hazard_pkg.sv
// hazard_pkg: opcodes, forwarding selects, FSM states and operand-use decode for hazard_ctrl
package hazard_pkg;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef enum logic [1:0] {RUN = 2'd0, DMISS = 2'd1, IMISS = 2'd2, IMISS_DROP = 2'd3} state_t;
  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction
  function automatic logic uses_rs2(input logic [6:0] op);
    return op == OP_R || op == OP_S || op == OP_B;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear (clk, rst, clr, inc -> cnt)
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= rst || clr ? '0 : inc && cnt != '1 ? cnt + CNT_W'(1) : cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: prioritised stall/flush/bubble control, operand forwarding selects and per-cause stall counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_valid,
  input  logic [6:0]            i_id_opcode,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rs1,
  input  logic [REG_ADDR_W-1:0] i_ex_rs2,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_regwrite,
  input  logic                  i_ex_memread,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_regwrite,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_regwrite,
  input  logic                  i_ex_redirect,
  input  logic                  i_imem_ren,
  input  logic                  i_imem_ready,
  input  logic                  i_dmem_req,
  input  logic                  i_dmem_ready,
  input  logic                  i_cnt_clr,
  output logic                  o_pc_en,
  output logic                  o_if_id_en,
  output logic                  o_id_ex_en,
  output logic                  o_ex_mem_en,
  output logic                  o_mem_wb_en,
  output logic                  o_if_flush,
  output logic                  o_id_bubble,
  output logic [1:0]            o_fwd_rs1,
  output logic [1:0]            o_fwd_rs2,
  output logic [CNT_W-1:0]      o_cnt_dcache,
  output logic [CNT_W-1:0]      o_cnt_icache,
  output logic [CNT_W-1:0]      o_cnt_load_use
);
  state_t state;
  logic u1, u2, b1, b2, load_use, raw_stall, d_stall, i_stall, drop;
  logic c_d, c_r, c_dr, c_i, c_h;
  function automatic logic hit(input logic [REG_ADDR_W-1:0] rd, input logic [REG_ADDR_W-1:0] rs);
    return rd == rs && rd != '0;
  endfunction
  assign u1 = uses_rs1(i_id_opcode);
  assign u2 = uses_rs2(i_id_opcode);
  assign b1 = i_ex_regwrite && hit(i_ex_rd, i_id_rs1) || i_mem_regwrite && hit(i_mem_rd, i_id_rs1);
  assign b2 = i_ex_regwrite && hit(i_ex_rd, i_id_rs2) || i_mem_regwrite && hit(i_mem_rd, i_id_rs2);
  assign load_use = i_id_valid && i_ex_memread && (u1 && hit(i_ex_rd, i_id_rs1) || u2 && hit(i_ex_rd, i_id_rs2));
  assign raw_stall = !FWD_EN && i_id_valid && (u1 && b1 || u2 && b2);
  assign d_stall = i_dmem_req && !i_dmem_ready;
  assign i_stall = i_imem_ren && !i_imem_ready;
  assign drop = state == IMISS_DROP;
  assign c_d  = d_stall;
  assign c_r  = !c_d && i_ex_redirect;
  assign c_dr = !c_d && !c_r && drop && i_imem_ready;
  assign c_i  = !c_d && !c_r && (i_stall || drop && !i_imem_ready);
  assign c_h  = !c_d && !c_r && !c_dr && !c_i && (load_use || raw_stall);
  assign o_pc_en     = !i_rst && !c_d && !c_dr && !c_i && !c_h;
  assign o_if_id_en  = !i_rst && !c_d && !c_i && !c_h;
  assign o_id_ex_en  = !i_rst && !c_d;
  assign o_ex_mem_en = !i_rst && !c_d;
  assign o_mem_wb_en = !i_rst && !c_d;
  assign o_if_flush  = i_rst || c_r || c_dr;
  assign o_id_bubble = i_rst || c_r || c_i || c_h;
  assign o_fwd_rs1 = i_rst || !FWD_EN ? FWD_RF : i_mem_regwrite && hit(i_mem_rd, i_ex_rs1) ? FWD_MEM :
                     i_wb_regwrite && hit(i_wb_rd, i_ex_rs1) ? FWD_WB : FWD_RF;
  assign o_fwd_rs2 = i_rst || !FWD_EN ? FWD_RF : i_mem_regwrite && hit(i_mem_rd, i_ex_rs2) ? FWD_MEM :
                     i_wb_regwrite && hit(i_wb_rd, i_ex_rs2) ? FWD_WB : FWD_RF;
  always_ff @(posedge i_clk)
    if (i_rst) state <= RUN;
    else
      case (state)
        RUN:     state <= d_stall ? DMISS : i_stall ? (i_ex_redirect ? IMISS_DROP : IMISS) : RUN;
        DMISS:   state <= i_dmem_ready ? RUN : DMISS;
        IMISS:   state <= i_ex_redirect && !d_stall ? IMISS_DROP : i_imem_ready ? RUN : IMISS;
        default: state <= i_imem_ready ? RUN : IMISS_DROP;
      endcase
  sat_counter #(.CNT_W(CNT_W)) u_cnt_d (.clk(i_clk), .rst(i_rst), .clr(i_cnt_clr), .inc(c_d), .cnt(o_cnt_dcache));
  sat_counter #(.CNT_W(CNT_W)) u_cnt_i (.clk(i_clk), .rst(i_rst), .clr(i_cnt_clr), .inc(c_i), .cnt(o_cnt_icache));
  sat_counter #(.CNT_W(CNT_W)) u_cnt_h (.clk(i_clk), .rst(i_rst), .clr(i_cnt_clr), .inc(c_h), .cnt(o_cnt_load_use));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table plus multi-cycle sequences for forwarding and no-forward builds of hazard_ctrl
module tb_hazard_ctrl;
  import hazard_pkg::*;
  localparam logic [6:0] NORM  = 7'b1111100;
  localparam logic [6:0] STALL = 7'b0011101;
  localparam logic [6:0] REDIR = 7'b1111111;
  localparam logic [6:0] DROP  = 7'b0111110;
  localparam logic [6:0] FROZE = 7'b0000000;
  localparam logic [6:0] RST   = 7'b0000011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  typedef struct {
    logic       id_valid;
    logic [6:0] op;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic       ex_rw, ex_mr;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic [4:0] wb_rd;
    logic       wb_rw, redir;
    logic [6:0] ctl_f;
    logic [1:0] fw1, fw2;
    logic [6:0] ctl_n;
  } vec_t;
  logic clk = 1'b0;
  logic i_rst, i_id_valid, i_ex_regwrite, i_ex_memread, i_mem_regwrite, i_wb_regwrite, i_ex_redirect;
  logic i_imem_ren, i_imem_ready, i_dmem_req, i_dmem_ready, i_cnt_clr;
  logic [6:0] i_id_opcode;
  logic [4:0] i_id_rs1, i_id_rs2, i_ex_rs1, i_ex_rs2, i_ex_rd, i_mem_rd, i_wb_rd;
  logic [4:0] f_en, n_en;
  logic f_fl, f_bu, n_fl, n_bu;
  logic [1:0] f_f1, f_f2, n_f1, n_f2;
  logic [31:0] f_cd, f_ci, f_cl;
  logic [3:0] n_cd, n_ci, n_cl;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(32)) u_f (
    .i_clk(clk), .i_rst(i_rst), .i_id_valid(i_id_valid), .i_id_opcode(i_id_opcode),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_ex_rs1(i_ex_rs1), .i_ex_rs2(i_ex_rs2),
    .i_ex_rd(i_ex_rd), .i_ex_regwrite(i_ex_regwrite), .i_ex_memread(i_ex_memread),
    .i_mem_rd(i_mem_rd), .i_mem_regwrite(i_mem_regwrite), .i_wb_rd(i_wb_rd), .i_wb_regwrite(i_wb_regwrite),
    .i_ex_redirect(i_ex_redirect), .i_imem_ren(i_imem_ren), .i_imem_ready(i_imem_ready),
    .i_dmem_req(i_dmem_req), .i_dmem_ready(i_dmem_ready), .i_cnt_clr(i_cnt_clr),
    .o_pc_en(f_en[4]), .o_if_id_en(f_en[3]), .o_id_ex_en(f_en[2]), .o_ex_mem_en(f_en[1]), .o_mem_wb_en(f_en[0]),
    .o_if_flush(f_fl), .o_id_bubble(f_bu), .o_fwd_rs1(f_f1), .o_fwd_rs2(f_f2),
    .o_cnt_dcache(f_cd), .o_cnt_icache(f_ci), .o_cnt_load_use(f_cl));
  hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(4)) u_n (
    .i_clk(clk), .i_rst(i_rst), .i_id_valid(i_id_valid), .i_id_opcode(i_id_opcode),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_ex_rs1(i_ex_rs1), .i_ex_rs2(i_ex_rs2),
    .i_ex_rd(i_ex_rd), .i_ex_regwrite(i_ex_regwrite), .i_ex_memread(i_ex_memread),
    .i_mem_rd(i_mem_rd), .i_mem_regwrite(i_mem_regwrite), .i_wb_rd(i_wb_rd), .i_wb_regwrite(i_wb_regwrite),
    .i_ex_redirect(i_ex_redirect), .i_imem_ren(i_imem_ren), .i_imem_ready(i_imem_ready),
    .i_dmem_req(i_dmem_req), .i_dmem_ready(i_dmem_ready), .i_cnt_clr(i_cnt_clr),
    .o_pc_en(n_en[4]), .o_if_id_en(n_en[3]), .o_id_ex_en(n_en[2]), .o_ex_mem_en(n_en[1]), .o_mem_wb_en(n_en[0]),
    .o_if_flush(n_fl), .o_id_bubble(n_bu), .o_fwd_rs1(n_f1), .o_fwd_rs2(n_f2),
    .o_cnt_dcache(n_cd), .o_cnt_icache(n_ci), .o_cnt_load_use(n_cl));
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic chkf(input string nm, input logic [6:0] ctl, input logic [1:0] a, input logic [1:0] b);
    chk(nm, 32'({f_en, f_fl, f_bu, f_f1, f_f2}), 32'({ctl, a, b}));
  endtask
  task automatic chkn(input string nm, input logic [6:0] ctl);
    chk(nm, 32'({n_en, n_fl, n_bu, n_f1, n_f2}), 32'({ctl, 4'b0000}));
  endtask
  task automatic chks(input string nm, input state_t s);
    chk(nm, 32'(u_f.state), 32'(s));
  endtask
  task automatic idle();
    {i_id_valid, i_ex_regwrite, i_ex_memread, i_mem_regwrite, i_wb_regwrite, i_ex_redirect} = '0;
    {i_imem_ren, i_dmem_req, i_cnt_clr} = '0;
    i_imem_ready = 1'b1;
    i_dmem_ready = 1'b1;
    i_id_opcode = OP_R;
    {i_id_rs1, i_id_rs2, i_ex_rs1, i_ex_rs2, i_ex_rd, i_mem_rd, i_wb_rd} = '0;
  endtask
  task automatic clr();
    i_cnt_clr = 1'b1;
    cyc();
    i_cnt_clr = 1'b0;
  endtask
  task automatic apply(input vec_t v);
    i_id_valid = v.id_valid; i_id_opcode = v.op; i_id_rs1 = v.id_rs1; i_id_rs2 = v.id_rs2;
    i_ex_rs1 = v.ex_rs1; i_ex_rs2 = v.ex_rs2; i_ex_rd = v.ex_rd; i_ex_regwrite = v.ex_rw; i_ex_memread = v.ex_mr;
    i_mem_rd = v.mem_rd; i_mem_regwrite = v.mem_rw; i_wb_rd = v.wb_rd; i_wb_regwrite = v.wb_rw;
    i_ex_redirect = v.redir;
  endtask
  function automatic vec_t mk(input logic iv, input logic [6:0] op, input logic [4:0] r1, r2, e1, e2, erd,
                              input logic erw, emr, input logic [4:0] mrd, input logic mrw,
                              input logic [4:0] wrd, input logic wrw, rdr,
                              input logic [6:0] cf, input logic [1:0] a, b, input logic [6:0] cn);
    vec_t v;
    v.id_valid = iv; v.op = op; v.id_rs1 = r1; v.id_rs2 = r2; v.ex_rs1 = e1; v.ex_rs2 = e2; v.ex_rd = erd;
    v.ex_rw = erw; v.ex_mr = emr; v.mem_rd = mrd; v.mem_rw = mrw; v.wb_rd = wrd; v.wb_rw = wrw; v.redir = rdr;
    v.ctl_f = cf; v.fw1 = a; v.fw2 = b; v.ctl_n = cn;
    return v;
  endfunction
  initial begin
    vec_t tv[16];
    tv[0]  = mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM,  2'b00, 2'b00, NORM);
    tv[1]  = mk(1, OP_R,   5, 7, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, STALL, 2'b00, 2'b00, STALL);
    tv[2]  = mk(1, OP_R,   1, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, STALL, 2'b00, 2'b00, STALL);
    tv[3]  = mk(1, OP_LUI, 5, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, NORM,  2'b00, 2'b00, NORM);
    tv[4]  = mk(1, OP_I,   1, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, NORM,  2'b00, 2'b00, NORM);
    tv[5]  = mk(1, OP_S,   1, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, STALL, 2'b00, 2'b00, STALL);
    tv[6]  = mk(1, OP_R,   0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, NORM,  2'b00, 2'b00, NORM);
    tv[7]  = mk(0, OP_R,   0, 0, 3, 4, 0, 0, 0, 3, 1, 3, 1, 0, NORM,  2'b10, 2'b00, NORM);
    tv[8]  = mk(0, OP_R,   0, 0, 3, 3, 0, 0, 0, 0, 1, 3, 1, 0, NORM,  2'b01, 2'b01, NORM);
    tv[9]  = mk(0, OP_R,   0, 0, 9, 4, 0, 0, 0, 9, 1, 4, 1, 0, NORM,  2'b10, 2'b01, NORM);
    tv[10] = mk(0, OP_R,   0, 0, 3, 0, 0, 0, 0, 3, 0, 3, 1, 0, NORM,  2'b01, 2'b00, NORM);
    tv[11] = mk(1, OP_R,   6, 2, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, NORM,  2'b00, 2'b00, STALL);
    tv[12] = mk(1, OP_R,   2, 8, 0, 0, 0, 0, 0, 8, 1, 0, 0, 0, NORM,  2'b00, 2'b00, STALL);
    tv[13] = mk(1, OP_R,   8, 0, 0, 0, 0, 0, 0, 0, 0, 8, 1, 0, NORM,  2'b00, 2'b00, NORM);
    tv[14] = mk(1, OP_R,   5, 7, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, REDIR, 2'b00, 2'b00, REDIR);
    tv[15] = mk(1, OP_R,   6, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, NORM,  2'b00, 2'b00, NORM);
    idle();
    i_rst = 1'b1; i_ex_rs1 = 3; i_mem_rd = 3; i_mem_regwrite = 1'b1; i_ex_redirect = 1'b1;
    #1 chkf("rst_out", RST, 2'b00, 2'b00);
    chkn("rst_out_n", RST);
    cyc(); cyc();
    chk("rst_cnt_f", f_cd | f_ci | f_cl, 0);
    chk("rst_cnt_n", 32'(n_cd | n_ci | n_cl), 0);
    chks("rst_state", RUN);
    i_rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      apply(tv[i]);
      #1 chkf($sformatf("vec%0d_f", i), tv[i].ctl_f, tv[i].fw1, tv[i].fw2);
      chkn($sformatf("vec%0d_n", i), tv[i].ctl_n);
      cyc();
    end
    idle(); clr();
    i_id_valid = 1; i_id_rs1 = 5; i_id_rs2 = 7; i_ex_rd = 5; i_ex_regwrite = 1; i_ex_memread = 1;
    #1 chkf("lu_stall", STALL, 2'b00, 2'b00);
    cyc();
    i_id_opcode = OP_I; i_id_rs1 = 1; i_ex_rs1 = 5; i_ex_rs2 = 7; i_ex_rd = 6; i_ex_memread = 0;
    i_mem_rd = 5; i_mem_regwrite = 1;
    #1 chkf("lu_resume", NORM, 2'b10, 2'b00);
    cyc();
    chk("lu_cnt", f_cl, 1);
    idle(); clr();
    i_id_valid = 1; i_id_rs1 = 5; i_id_rs2 = 7; i_ex_rd = 5; i_ex_regwrite = 1;
    #1 chkf("raw_f", NORM, 2'b00, 2'b00);
    chkn("raw_n1", STALL);
    cyc();
    i_ex_rd = 0; i_ex_regwrite = 0; i_mem_rd = 5; i_mem_regwrite = 1;
    #1 chkn("raw_n2", STALL);
    cyc();
    i_mem_rd = 0; i_mem_regwrite = 0; i_wb_rd = 5; i_wb_regwrite = 1;
    #1 chkn("raw_n3", NORM);
    cyc();
    chk("raw_cnt", 32'(n_cl), 2);
    idle(); clr();
    i_imem_ren = 1; i_imem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1 chkf($sformatf("imiss%0d", k), STALL, 2'b00, 2'b00);
      cyc();
    end
    i_imem_ready = 1;
    #1 chkf("imiss_done", NORM, 2'b00, 2'b00);
    cyc();
    chk("imiss_cnt", f_ci, 3);
    chks("imiss_state", RUN);
    idle(); clr();
    i_imem_ren = 1; i_imem_ready = 0;
    #1 chkf("rd_c0", STALL, 2'b00, 2'b00);
    cyc();
    i_ex_redirect = 1;
    #1 chkf("rd_c1", REDIR, 2'b00, 2'b00);
    cyc();
    i_ex_redirect = 0;
    chks("rd_state_drop", IMISS_DROP);
    for (int k = 2; k < 4; k++) begin
      #1 chkf($sformatf("rd_c%0d", k), STALL, 2'b00, 2'b00);
      cyc();
    end
    i_imem_ready = 1;
    #1 chkf("rd_ready", DROP, 2'b00, 2'b00);
    cyc();
    chks("rd_state_run", RUN);
    #1 chkf("rd_after", NORM, 2'b00, 2'b00);
    chk("rd_cnt", f_ci, 3);
    cyc();
    idle(); clr();
    i_dmem_req = 1; i_dmem_ready = 0; i_imem_ren = 1; i_imem_ready = 0; i_ex_redirect = 1;
    for (int k = 0; k < 3; k++) begin
      #1 chkf($sformatf("dm%0d", k), FROZE, 2'b00, 2'b00);
      cyc();
    end
    i_dmem_ready = 1;
    #1 chkf("dm_ready", REDIR, 2'b00, 2'b00);
    cyc();
    chk("dm_cnt_d", f_cd, 3);
    chk("dm_cnt_i", f_ci, 0);
    chk("dm_cnt_l", f_cl, 0);
    i_ex_redirect = 0;
    #1 chkf("dm_imiss", STALL, 2'b00, 2'b00);
    cyc();
    i_imem_ready = 1;
    #1 chkf("dm_idone", NORM, 2'b00, 2'b00);
    cyc();
    chk("dm_cnt_i2", f_ci, 1);
    chks("dm_state", RUN);
    idle(); clr();
    i_dmem_req = 1; i_dmem_ready = 0;
    for (int k = 0; k < 20; k++) cyc();
    chk("sat_n", 32'(n_cd), 15);
    chk("sat_f", f_cd, 20);
    i_cnt_clr = 1;
    cyc();
    i_cnt_clr = 0;
    chk("clr_n", 32'(n_cd), 0);
    chk("clr_f", f_cd, 0);
    idle();
    cyc();
    chks("sat_state", RUN);
    i_imem_ren = 1; i_imem_ready = 0;
    cyc();
    i_ex_redirect = 1;
    cyc();
    i_ex_redirect = 0;
    chks("rst_drop_state", IMISS_DROP);
    i_rst = 1;
    #1 chkf("rst_drop_out", RST, 2'b00, 2'b00);
    cyc();
    i_rst = 0; i_imem_ready = 1;
    chks("rst_drop_run", RUN);
    chk("rst_drop_cnt", f_ci, 0);
    #1 chkf("rst_drop_after", NORM, 2'b00, 2'b00);
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
